// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Stands in for the legacy defines: bus widths, ROM size, chip-enable levels, state encodings.
package inst_fetch_ctrl_pkg;

    localparam int unsigned INST_ADDR_W  = 32;
    localparam int unsigned INST_W       = 32;
    localparam int unsigned INST_MEM_NUM = 64;

    localparam logic             CHIP_ENABLE  = 1'b1;
    localparam logic             CHIP_DISABLE = 1'b0;
    localparam logic [INST_W-1:0] ZERO_WORD   = '0;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StFetch = 2'b01,
        StFault = 2'b10
    } if_state_e;

    // A PC is unusable when misaligned or outside the ROM.
    function automatic logic pc_is_bad(input logic [INST_ADDR_W-1:0] pc,
                                       input logic [INST_ADDR_W-1:0] rom_bytes);
        return (pc[1:0] != 2'b00) || (pc >= rom_bytes);
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_fifo.sv
// Prefetch FIFO of {pc,inst} entries with push, pop and synchronous clear.
// Head entry is read straight from the storage registers, so the outputs are registered.
module inst_fetch_ctrl_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 64,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [W-1:0]     wdata_i,
    output logic [W-1:0]     rdata_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     r_mem [DEPTH];
    logic [CNT_W-1:0] r_wptr;
    logic [CNT_W-1:0] r_rptr;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign count_o   = r_wptr - r_rptr;
    assign empty_o   = (r_wptr == r_rptr);
    assign w_full    = (count_o == CNT_W'(DEPTH));
    assign rdata_o   = r_mem[r_rptr[AW-1:0]];
    assign w_do_pop  = pop_i && !empty_o && !clear_i;
    // Push into a full FIFO is only legal when the head leaves on the same edge.
    assign w_do_push = push_i && !clear_i && (!w_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr[AW-1:0]] <= wdata_i;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, drives the combinational ROM, buffers words in a
// prefetch FIFO toward ID, and handles stall, flush redirect and PC faults.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned            FIFO_DEPTH = 2,
    parameter int unsigned            ROM_BYTES  = INST_MEM_NUM * 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_en_o,
    output logic [INST_ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0]      rom_inst_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [INST_ADDR_W-1:0] flush_pc_i,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output logic [INST_ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0]      id_inst_o,
    output logic                   fetch_fault_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [INST_ADDR_W-1:0] ROM_LIMIT = INST_ADDR_W'(ROM_BYTES);

    if_state_e                      r_state;
    if_state_e                      w_state_nxt;
    logic [INST_ADDR_W-1:0]         r_pc;
    logic [INST_ADDR_W-1:0]         w_pc_nxt;

    logic                           w_empty;
    logic [CNT_W-1:0]               w_count;
    logic [INST_ADDR_W+INST_W-1:0]  w_head;
    logic                           w_pop_req;
    logic                           w_can_push;
    logic                           w_fetch_ok;
    logic                           w_pc_bad;
    logic                           w_fetch;

    assign id_valid_o = !w_empty;
    assign w_pop_req  = id_valid_o && id_ready_i;
    assign w_can_push = (w_count < CNT_W'(FIFO_DEPTH)) || w_pop_req;
    assign w_fetch_ok = (r_state == StFetch) && w_can_push && !stall_i && !flush_i;
    assign w_pc_bad   = pc_is_bad(r_pc, ROM_LIMIT);
    assign w_fetch    = w_fetch_ok && !w_pc_bad;

    assign rom_en_o      = w_fetch ? CHIP_ENABLE : CHIP_DISABLE;
    // Address holds the PC outside fetch cycles; only the idle cycle after reset shows zero.
    assign rom_addr_o    = (r_state == StIdle) ? '0 : r_pc;
    assign fetch_fault_o = (r_state == StFault);
    assign id_pc_o       = w_head[INST_ADDR_W+INST_W-1:INST_W];
    assign id_inst_o     = w_head[INST_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        unique case (r_state)
            StIdle: begin
                w_state_nxt = StFetch;
            end
            StFetch, StFault: begin
                if (flush_i) begin
                    w_pc_nxt    = flush_pc_i;
                    w_state_nxt = pc_is_bad(flush_pc_i, ROM_LIMIT) ? StFault : StFetch;
                end else if (r_state == StFetch && w_fetch_ok) begin
                    if (w_pc_bad) begin
                        w_state_nxt = StFault;
                    end else begin
                        w_pc_nxt = r_pc + 32'd4;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    inst_fetch_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (INST_ADDR_W + INST_W)
    ) u_fetch_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_fetch),
        .pop_i   (w_pop_req),
        .clear_i (flush_i),
        .wdata_i ({r_pc, rom_inst_i}),
        .rdata_o (w_head),
        .empty_o (w_empty),
        .count_o (w_count)
    );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: a queue-based model predicts fetches and FIFO contents,
// a negedge monitor checks the ID-side head against the expected queue.
module tb_inst_fetch_ctrl;

    localparam int unsigned DEPTH     = 2;
    localparam int unsigned ROM_BYTES = 256;

    logic        clk;
    logic        rst;
    logic        rom_en_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        fetch_fault_o;

    int          tests;
    int          fails;

    // Model state: expected FIFO contents, PC, fault flag, idle-after-reset flag.
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic        m_fault;
    logic        m_idle;
    logic        mon_en;

    inst_fetch_ctrl #(
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (DEPTH),
        .ROM_BYTES  (ROM_BYTES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_en_o      (rom_en_o),
        .rom_addr_o    (rom_addr_o),
        .rom_inst_i    (rom_inst_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .flush_pc_i    (flush_pc_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .fetch_fault_o (fetch_fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h1357};
    endfunction

    function automatic logic bad_pc(input logic [31:0] a);
        return (a % 4 != 0) || (a >= ROM_BYTES);
    endfunction

    assign rom_inst_i = rom_word(rom_addr_o);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: ID-side head and pops, compared against the expected queue.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("id_valid", {63'd0, id_valid_o}, {63'd0, m_q.size() != 0});
            if (m_q.size() != 0) begin
                check("id_head", {id_pc_o, id_inst_o}, m_q[0]);
                if (id_ready_i && !flush_i) begin
                    void'(m_q.pop_front());
                end
            end
        end
    end

    // One cycle: drive inputs, then after the monitor has consumed this cycle's pop, predict
    // the ROM side from the model and advance the model across the coming edge.
    task automatic step(input logic st, input logic fl, input logic [31:0] fpc, input logic rdy);
        logic exp_en;
        stall_i    = st;
        flush_i    = fl;
        flush_pc_i = fpc;
        id_ready_i = rdy;
        @(negedge clk);
        #1;
        exp_en = !m_idle && !m_fault && !fl && !st && (m_q.size() < DEPTH) && !bad_pc(m_pc);
        check("rom_en", {63'd0, rom_en_o}, {63'd0, exp_en});
        check("rom_addr", {32'd0, rom_addr_o}, {32'd0, m_idle ? 32'd0 : m_pc});
        check("fault", {63'd0, fetch_fault_o}, {63'd0, m_fault});
        if (m_idle) begin
            m_idle = 1'b0;
        end else if (fl) begin
            m_q.delete();
            m_pc    = fpc;
            m_fault = bad_pc(fpc);
        end else if (!m_fault && !st && m_q.size() < DEPTH) begin
            if (bad_pc(m_pc)) begin
                m_fault = 1'b1;
            end else begin
                m_q.push_back({m_pc, rom_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, {63'd0, rom_en_o}, 64'd0);
        check({tag, "_addr"}, {32'd0, rom_addr_o}, 64'd0);
        check({tag, "_valid"}, {63'd0, id_valid_o}, 64'd0);
        check({tag, "_head"}, {id_pc_o, id_inst_o}, 64'd0);
        check({tag, "_fault"}, {63'd0, fetch_fault_o}, 64'd0);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc    = 32'h0;
        m_fault = 1'b0;
        m_idle  = 1'b1;
    endtask

    initial begin
        logic [31:0] fpc;
        int          sel;
        tests      = 0;
        fails      = 0;
        mon_en     = 1'b0;
        rst        = 1'b1;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
        flush_pc_i = 32'h0;
        id_ready_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst    = 1'b0;
        mon_en = 1'b1;

        // Streaming with ID always ready, then back-pressure, then resume.
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Flush while full and stalled.
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h40, 1'b0);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Misaligned redirect faults; legal redirect recovers.
        step(1'b0, 1'b1, 32'h42, 1'b1);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h10, 1'b1);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Run off the end of the ROM.
        step(1'b0, 1'b1, ROM_BYTES - 4, 1'b1);
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h20, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            fpc = 32'h0;
            if ($urandom_range(0, 9) == 0) begin
                sel = int'($urandom_range(0, 9));
                case (sel)
                    0:       fpc = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
                    1:       fpc = ROM_BYTES + 4 * $urandom_range(0, 255);
                    2:       fpc = ROM_BYTES - 4 * $urandom_range(1, 2);
                    default: fpc = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                endcase
                step($urandom_range(0, 4) == 0, 1'b1, fpc, $urandom_range(0, 9) < 7);
            end else begin
                step($urandom_range(0, 4) == 0, 1'b0, 32'h0, $urandom_range(0, 9) < 7);
            end
        end

        // Asynchronous reset between clock edges while fetching.
        step(1'b0, 1'b1, 32'h8, 1'b1);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        rst        = 1'b0;
        model_reset();
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
